// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pulls words from a fall-through FIFO, tags every PKT_LEN-th word as the end
// of a packet and presents the words on a valid/ready stream through a
// 2-entry in-order output buffer.
// Optional feature: define FIFO_READER_STATS_EN to add the word_count and
// pkt_count statistics outputs.

module fifo_stream_reader #(
    parameter int DATAWIDTH = 8,
    parameter int PKT_LEN   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATAWIDTH-1:0] fifo_rdata,
    output logic                 fifo_r_en,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
`ifdef FIFO_READER_STATS_EN
    output logic [CNT_W-1:0]     word_count,
    output logic [CNT_W-1:0]     pkt_count,
`endif
    output logic                 busy
);

    if (PKT_LEN < 1 || PKT_LEN > 256 || CNT_W < 1) begin : g_bad_params
        $error("fifo_stream_reader: PKT_LEN must be 1..256 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [7:0] PKT_LAST = 8'(PKT_LEN - 1);

    state_t               state_q, state_d;
    logic [1:0]           occ_q, occ_d;
    logic [7:0]           pkt_idx_q, pkt_idx_d;
    logic [DATAWIDTH-1:0] head_data_q, head_data_d;
    logic                 head_last_q, head_last_d;
    logic [DATAWIDTH-1:0] tail_data_q, tail_data_d;
    logic                 tail_last_q, tail_last_d;

    logic push;       // FIFO word enters the buffer at this edge
    logic pop;        // head word leaves on the stream at this edge
    logic push_last;  // the word being pushed closes its packet

    assign push      = fifo_r_en;
    assign push_last = (pkt_idx_q == PKT_LAST);
    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = head_data_q;
    assign out_last  = head_last_q;
    assign busy      = (occ_q != 2'd0) | (pkt_idx_q != 8'd0);

    // FSM state register.
    always_ff @(posedge rclk) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // flop samples pre-edge values regardless of process ordering.
        if (rrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; decisions use the packet index as it will be after this
    // cycle's pop, so a pop coinciding with enable falling is never stranded.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_d = (pkt_idx_d == 8'd0) ? ST_IDLE : ST_STOPPING;
            end
            ST_STOPPING: begin
                if (enable)                 state_d = ST_RUN;
                else if (push && push_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output: pop the FIFO while streaming and the buffer has room.
    always_comb begin
        fifo_r_en = 1'b0;
        if (!rrst && !fifo_empty && (occ_q != 2'd2) &&
            (state_q == ST_RUN || state_q == ST_STOPPING)) begin
            fifo_r_en = 1'b1;
        end
    end

    // Packet position: advance on each pop, wrap after the last word.
    always_comb begin
        pkt_idx_d = pkt_idx_q;
        if (push) pkt_idx_d = push_last ? 8'd0 : pkt_idx_q + 8'd1;
    end

    // Output buffer: head feeds the stream directly, tail holds the second word.
    always_comb begin
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        occ_d       = occ_q + 2'(push) - 2'(pop);
        if (pop) begin
            if (occ_q == 2'd2) begin
                head_data_d = tail_data_q;
                head_last_d = tail_last_q;
            end else if (push) begin
                head_data_d = fifo_rdata;
                head_last_d = push_last;
            end else begin
                // Buffer runs empty: data holds, last must read 0.
                head_last_d = 1'b0;
            end
        end else if (push) begin
            if (occ_q == 2'd0) begin
                head_data_d = fifo_rdata;
                head_last_d = push_last;
            end else begin
                tail_data_d = fifo_rdata;
                tail_last_d = push_last;
            end
        end
    end

    // Control and head registers, cleared by reset.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ_q       <= 2'd0;
            pkt_idx_q   <= 8'd0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            pkt_idx_q   <= pkt_idx_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
        end
    end

    // Tail entry storage.
    always_ff @(posedge rclk) begin
        // NOTE: pure storage is left unreset; it is only read when occ_q says
        // it holds a word, so its power-up contents are never observed.
        tail_data_q <= tail_data_d;
        tail_last_q <= tail_last_d;
    end

`ifdef FIFO_READER_STATS_EN
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

    // Statistics: count stream transfers and completed packets, wrapping.
    always_comb begin
        word_count_d = word_count_q;
        pkt_count_d  = pkt_count_q;
        if (pop) begin
            word_count_d = word_count_q + CNT_W'(1);
            if (head_last_q) pkt_count_d = pkt_count_q + CNT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            word_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            word_count_q <= word_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign word_count = word_count_q;
    assign pkt_count  = pkt_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: a queue models the FIFO, a scoreboard
// queue holds the words expected on the stream in order, with last flags
// derived from an independent packet counter.

module tb_fifo_stream_reader;

    localparam int DW      = 8;
    localparam int PKT_LEN = 4;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } entry_t;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_r_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;
`ifdef FIFO_READER_STATS_EN
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] pkt_count;
`endif

    always #5 rclk = ~rclk;

    fifo_stream_reader #(
        .DATAWIDTH (DW),
        .PKT_LEN   (PKT_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_r_en  (fifo_r_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
`ifdef FIFO_READER_STATS_EN
        .word_count (word_count),
        .pkt_count  (pkt_count),
`endif
        .busy       (busy)
    );

    int      n_tests     = 0;
    int      n_fail      = 0;
    logic [DW-1:0] fifo_mem[$];
    entry_t  sb[$];
    entry_t  xfer_log[$];
    int      tb_idx      = 0;
    int      cyc         = 0;
    int      n_pops      = 0;
    int      first_ren   = -1;
    int      first_valid = -1;
    bit      chk_en      = 1'b0;

    // Drive FIFO-side inputs from the model, let logic settle, run per-cycle checks.
    task automatic settle();
        fifo_empty = (fifo_mem.size() == 0);
        fifo_rdata = (fifo_mem.size() == 0) ? '0 : fifo_mem[0];
        #1;
        if (rrst) begin
            n_tests++;
            if (fifo_r_en !== 1'b0) begin
                n_fail++;
                $display("FAIL ren_in_reset: cyc=%0d fifo_r_en=%b expected 0", cyc, fifo_r_en);
            end
        end
        if (chk_en) begin
            n_tests++;
            if (fifo_r_en === 1'b1 && (fifo_empty || sb.size() >= 2)) begin
                n_fail++;
                $display("FAIL ren_rule: cyc=%0d fifo_r_en=1 with empty=%b occ=%0d", cyc, fifo_empty, sb.size());
            end
            n_tests++;
            if (out_valid !== (sb.size() != 0)) begin
                n_fail++;
                $display("FAIL out_valid: cyc=%0d got %b expected %b", cyc, out_valid, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                n_tests++;
                if ({out_last, out_data} !== sb[0]) begin
                    n_fail++;
                    $display("FAIL out_head: cyc=%0d got last=%b data=%h expected last=%b data=%h",
                             cyc, out_last, out_data, sb[0].last, sb[0].data);
                end
            end else begin
                n_tests++;
                if (out_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL out_last_idle: cyc=%0d got %b expected 0", cyc, out_last);
                end
            end
            n_tests++;
            if (busy !== ((sb.size() != 0) || (tb_idx != 0))) begin
                n_fail++;
                $display("FAIL busy: cyc=%0d got %b expected %b", cyc, busy, (sb.size() != 0) || (tb_idx != 0));
            end
        end
        if (fifo_r_en === 1'b1 && first_ren < 0)   first_ren   = cyc;
        if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    endtask

    // Account for what happens at the coming edge, then move to the next negedge.
    task automatic advance();
        entry_t e;
        if (rrst) begin
            sb.delete();
            tb_idx = 0;
        end else begin
            if (out_valid === 1'b1 && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                xfer_log.push_back(e);
            end
            if (fifo_r_en === 1'b1 && fifo_mem.size() != 0) begin
                e.data = fifo_mem.pop_front();
                e.last = (tb_idx == PKT_LEN - 1);
                sb.push_back(e);
                tb_idx = (tb_idx == PKT_LEN - 1) ? 0 : tb_idx + 1;
                n_pops++;
            end
        end
        cyc++;
        @(negedge rclk);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    // Compare the transfer log against a run of consecutive words starting at base.
    task automatic check_log(input string name, input int base, input int count);
        entry_t exp;
        n_tests++;
        if (xfer_log.size() != count) begin
            n_fail++;
            $display("FAIL %s_count: got %0d transfers expected %0d", name, xfer_log.size(), count);
        end
        for (int i = 0; i < xfer_log.size() && i < count; i++) begin
            exp.data = DW'(base + i);
            exp.last = ((i % PKT_LEN) == PKT_LEN - 1);
            n_tests++;
            if (xfer_log[i] !== exp) begin
                n_fail++;
                $display("FAIL %s_word%0d: got last=%b data=%h expected last=%b data=%h",
                         name, i, xfer_log[i].last, xfer_log[i].data, exp.last, exp.data);
            end
        end
    endtask

    task automatic test_reset();
        rrst = 1'b1; enable = 1'b1; out_ready = 1'b0;
        fifo_mem.push_back(8'hAA);
        cycle();
        cycle();
        rrst = 1'b0; enable = 1'b0; chk_en = 1'b1;
        settle();
        n_tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b last=%b data=%h busy=%b expected 0/0/00/0",
                     out_valid, out_last, out_data, busy);
        end
        n_tests++;
        if (fifo_r_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_ren: fifo_r_en=%b expected 0", fifo_r_en);
        end
        advance();
        fifo_mem.delete();
    endtask

    task automatic test_basic();
        xfer_log.delete(); first_ren = -1; first_valid = -1;
        for (int i = 0; i < 8; i++) fifo_mem.push_back(DW'(16 + i));
        enable = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 40 && xfer_log.size() < 8; k++) cycle();
        check_log("basic", 16, 8);
        n_tests++;
        if (first_valid - first_ren != 1) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles expected 1", first_valid - first_ren);
        end
        enable = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_backpressure();
        xfer_log.delete();
        for (int i = 0; i < 8; i++) fifo_mem.push_back(DW'(32 + i));
        enable = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            if (k >= 2) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== 8'h20) begin
                    n_fail++;
                    $display("FAIL bp_frozen: k=%0d valid=%b data=%h expected 1/20", k, out_valid, out_data);
                end
            end
            if (k >= 3) begin
                n_tests++;
                if (fifo_r_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_full_ren: k=%0d fifo_r_en=%b expected 0", k, fifo_r_en);
                end
            end
            advance();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && xfer_log.size() < 8; k++) cycle();
        check_log("bp", 32, 8);
        enable = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_stop();
        xfer_log.delete(); n_pops = 0;
        fifo_mem.push_back(8'h30);
        fifo_mem.push_back(8'h31);
        enable = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 20 && n_pops < 2; k++) cycle();
        n_tests++;
        if (n_pops != 2) begin
            n_fail++;
            $display("FAIL stop_first_pops: got %0d expected 2", n_pops);
        end
        enable = 1'b0; n_pops = 0;
        repeat (2) cycle();
        settle();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_busy_stall: busy=%b expected 1", busy);
        end
        advance();
        for (int i = 0; i < 4; i++) fifo_mem.push_back(DW'(50 + i));
        repeat (10) cycle();
        n_tests++;
        if (n_pops != 2 || fifo_mem.size() != 2) begin
            n_fail++;
            $display("FAIL stop_more_pops: got %0d pops (%0d left) expected 2 (2 left)", n_pops, fifo_mem.size());
        end
        settle();
        n_tests++;
        if (fifo_r_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: fifo_r_en=%b busy=%b expected 0/0 with FIFO non-empty", fifo_r_en, busy);
        end
        advance();
        check_log("stop", 48, 4);
        fifo_mem.delete();
    endtask

    task automatic test_underrun();
        xfer_log.delete(); n_pops = 0;
        fifo_mem.push_back(8'h40);
        enable = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 20 && n_pops < 1; k++) cycle();
        for (int k = 0; k < 6; k++) begin
            settle();
            n_tests++;
            if (fifo_r_en !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL underrun_stall: k=%0d fifo_r_en=%b busy=%b expected 0/1", k, fifo_r_en, busy);
            end
            advance();
        end
        for (int i = 1; i < 4; i++) fifo_mem.push_back(DW'(64 + i));
        for (int k = 0; k < 20 && xfer_log.size() < 4; k++) cycle();
        check_log("underrun", 64, 4);
        enable = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_reset_mid();
        xfer_log.delete(); n_pops = 0;
        for (int i = 0; i < 6; i++) fifo_mem.push_back(DW'(80 + i));
        enable = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 20 && n_pops < 2; k++) cycle();
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        settle();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: valid=%b busy=%b expected 0/0", out_valid, busy);
        end
        advance();
        out_ready = 1'b1;
        for (int k = 0; k < 30 && xfer_log.size() < 4; k++) cycle();
        check_log("rst_mid", 82, 4);
        enable = 1'b0;
        repeat (3) cycle();
    endtask

`ifdef FIFO_READER_STATS_EN
    task automatic test_stats();
        rrst = 1'b1; enable = 1'b0; out_ready = 1'b1;
        cycle();
        rrst = 1'b0;
        settle();
        n_tests++;
        if (word_count !== '0 || pkt_count !== '0) begin
            n_fail++;
            $display("FAIL stats_reset0: words=%0d pkts=%0d expected 0/0", word_count, pkt_count);
        end
        advance();
        xfer_log.delete();
        for (int i = 0; i < 12; i++) fifo_mem.push_back(DW'(96 + i));
        enable = 1'b1;
        for (int k = 0; k < 60 && xfer_log.size() < 12; k++) cycle();
        settle();
        n_tests++;
        if (word_count !== CNT_W'(12) || pkt_count !== CNT_W'(3)) begin
            n_fail++;
            $display("FAIL stats_counts: words=%0d pkts=%0d expected 12/3", word_count, pkt_count);
        end
        advance();
        enable = 1'b0;
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        settle();
        n_tests++;
        if (word_count !== '0 || pkt_count !== '0) begin
            n_fail++;
            $display("FAIL stats_reset1: words=%0d pkts=%0d expected 0/0", word_count, pkt_count);
        end
        advance();
    endtask
`endif

    initial begin
        rrst = 1'b1; enable = 1'b0; out_ready = 1'b0;
        fifo_empty = 1'b1; fifo_rdata = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stop();
        test_underrun();
        test_reset_mid();
`ifdef FIFO_READER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The block SHALL have these parameters:
- DATAWIDTH, default 8, FIFO word width.
- PKT_LEN, default 4, words per packet, legal range 1..256.
- CNT_W, default 16, statistics counter width.

REQ-002 The block SHALL have these ports:
- rclk  in  1  sole clock; all logic on posedge.
- rrst  in  1  synchronous, active-high reset.
- enable  in  1  request to stream packets.
- fifo_empty  in  1  empty flag from the FIFO read side.
- fifo_rdata  in  DATAWIDTH  FIFO head word, valid while fifo_empty=0 (fall-through).
- fifo_r_en  out  1  FIFO pop strobe.
- out_data  out  DATAWIDTH  stream data.
- out_valid  out  1  stream valid.
- out_last  out  1  final word of a packet.
- out_ready  in  1  downstream accept.
- busy  out  1  occupancy nonzero or packet in progress.

Function
REQ-003 The block SHALL hold a 2-entry in-order output buffer; each entry stores {last, data}; occ ranges 0..2.
REQ-004 fifo_r_en SHALL be combinational: 1 when fifo_empty=0, occ<2 and state is RUN or STOPPING; otherwise 0.
REQ-005 On a cycle with fifo_r_en=1, fifo_rdata SHALL be written into the buffer at the next rclk edge; latency from FIFO word to out_valid is 1 cycle.
REQ-006 out_valid SHALL equal (occ!=0); out_data and out_last SHALL come from the head entry, registered; with occ=0, out_data keeps its last value and out_last=0.
REQ-007 A transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; the head is then removed.
REQ-008 While out_valid=1 and out_ready=0, out_data and out_last SHALL remain stable.
REQ-009 A same-cycle FIFO pop and stream transfer SHALL leave occ unchanged and preserve word order.
REQ-010 pkt_idx (8 bits, 0..PKT_LEN-1) SHALL increment on each FIFO pop and wrap to 0 after PKT_LEN-1.
REQ-011 The popped word's last flag SHALL be 1 exactly when pkt_idx=PKT_LEN-1 at the pop; with PKT_LEN=1 every word is last.
REQ-012 The state machine SHALL have three states:
- IDLE: enable=1 goes to RUN.
- RUN: enable=0 with pkt_idx=0 goes to IDLE; enable=0 with pkt_idx!=0 goes to STOPPING.
- STOPPING: the block keeps popping until the pop with last=1, then goes to IDLE; enable=1 returns to RUN.
REQ-013 In IDLE, fifo_r_en SHALL be 0, and words already buffered SHALL still drain to the output.
REQ-014 busy SHALL be (occ!=0) | (pkt_idx!=0).
REQ-015 A FIFO underrun (fifo_empty=1) mid-packet SHALL only stall; pkt_idx SHALL be held, with no timeout and no padding.

Reset
REQ-016 While rrst=1 at a rclk edge, the block SHALL set:
- state to IDLE, occ=0, pkt_idx=0;
- out_valid=0, out_last=0, out_data=0;
- statistics counters to 0.
REQ-017 fifo_r_en SHALL be 0 in any cycle where rrst=1.
REQ-018 A reset mid-packet SHALL discard buffered words; the next popped word SHALL start a new packet (pkt_idx=0).

Configuration
REQ-019 Macro FIFO_READER_STATS_EN, when defined, SHALL add these outputs:
- word_count [CNT_W-1:0]: +1 per stream transfer.
- pkt_count [CNT_W-1:0]: +1 per transfer with out_last=1.
- Both counters wrap modulo 2^CNT_W and are cleared by rrst.
REQ-020 Without FIFO_READER_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Basic streaming: PKT_LEN=4, FIFO holds 0x10..0x17, enable=1, out_ready=1 -> 8 transfers in order, out_last on 0x13 and 0x17, first out_valid 1 cycle after first fifo_r_en.
- Backpressure: out_ready=0 for 5 cycles with FIFO non-empty -> occ reaches 2, fifo_r_en=0, out_data frozen; release -> no loss or duplicate.
- Packet-boundary stop: enable drops after 2 of 4 words -> STOPPING, exactly 2 more pops, last on the 4th word, then IDLE with fifo_r_en=0 despite fifo_empty=0.
- Underrun: FIFO empties after word 1 of a packet, refills 6 cycles later -> pkt_idx held, out_last on the correct 4th word.
- Reset mid-packet: rrst high 1 cycle with occ=2 and pkt_idx=2 -> out_valid=0 next cycle; next packet's last is on its 4th word.
- Stats (macro defined): 3 full packets transferred -> word_count=12, pkt_count=3; after rrst both read 0.
